// File: rtl/booth_pp_accumulator.sv
// Carry-save accumulator for radix-4 Booth partial products: one beat per cycle,
// then a single carry-propagate add delivers the product on a valid/ready port.
module booth_pp_accumulator #(
  parameter int W   = 64,
  parameter int NPP = 17,
  parameter int CW  = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pp_valid,
  output logic         pp_ready,
  input  logic [W-1:0] pp_data,
  input  logic         pp_last,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         res_err
);

  typedef enum logic [1:0] {ACCUM, RESOLVE, DONE} state_t;

  localparam logic [CW:0] NPP_C = (CW+1)'(NPP);

  state_t         state_r;
  logic [W-1:0]   sum_r;
  logic [W-1:0]   car_r;
  logic [W-1:0]   res_r;
  logic [CW-1:0]  cnt_r;
  logic           err_r;

  logic           beat_acc;
  logic [CW:0]    cnt_inc;
  logic           cnt_err;

  function automatic logic [W-1:0] csa_sum(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [W-1:0] c);
    return a ^ b ^ c;
  endfunction

  // Carry out of the MSB falls off the shift; the result is modulo 2^W anyway.
  function automatic logic [W-1:0] csa_car(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [W-1:0] c);
    return ((a & b) | (a & c) | (b & c)) << 1;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (&c) ? c : c + CW'(1);
  endfunction

  assign beat_acc = pp_valid && (state_r == ACCUM);
  // One extra bit so a saturated counter still compares as over-count.
  assign cnt_inc  = {1'b0, cnt_r} + (CW+1)'(1);
  assign cnt_err  = pp_last ? (cnt_inc != NPP_C) : (cnt_inc >= NPP_C);

  assign pp_ready  = (state_r == ACCUM);
  assign res_valid = (state_r == DONE);
  assign res_data  = res_r;
  assign res_err   = (state_r == DONE) && err_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ACCUM;
      sum_r   <= '0;
      car_r   <= '0;
      res_r   <= '0;
      cnt_r   <= '0;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        ACCUM: begin
          if (beat_acc) begin
            sum_r <= csa_sum(sum_r, car_r, pp_data);
            car_r <= csa_car(sum_r, car_r, pp_data);
            cnt_r <= sat_inc(cnt_r);
            if (cnt_err) err_r <= 1'b1;
            if (pp_last) state_r <= RESOLVE;
          end
        end
        RESOLVE: begin
          res_r   <= sum_r + car_r;
          state_r <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            sum_r   <= '0;
            car_r   <= '0;
            cnt_r   <= '0;
            err_r   <= 1'b0;
            state_r <= ACCUM;
          end
        end
        default: state_r <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Bench for booth_pp_accumulator: vector table, randomized operations against a
// plain modular-sum model, and hand sequences for backpressure, back-to-back and reset.
module tb_booth_pp_accumulator;
  localparam int W   = 64;
  localparam int NPP = 17;
  localparam int CW  = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pp_valid = 1'b0;
  logic         pp_ready;
  logic [W-1:0] pp_data = '0;
  logic         pp_last = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic [W-1:0] res_data;
  logic         res_err;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int acc_cnt = 0;
  int           hs_cyc[$];
  logic [W-1:0] hs_data[$];
  logic [W-1:0] beat_q[$];

  typedef struct {
    int           nbeats;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic [W-1:0] drest;
    logic [W-1:0] exp_data;
    logic         exp_err;
  } vec_t;
  vec_t vecs[7];

  booth_pp_accumulator #(.W(W), .NPP(NPP), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .pp_valid(pp_valid), .pp_ready(pp_ready), .pp_data(pp_data), .pp_last(pp_last),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pp_valid && pp_ready) acc_cnt <= acc_cnt + 1;
    if (res_valid && res_ready) begin
      hs_cyc.push_back(cyc);
      hs_data.push_back(res_data);
    end
  end

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic check_bit(input string nm, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  function automatic logic [W-1:0] ref_sum();
    logic [W-1:0] s = '0;
    foreach (beat_q[i]) s = s + beat_q[i];
    return s;
  endfunction

  // Presents a beat at the falling edge and returns at the rising edge that accepts it.
  task automatic send_beat(input logic [W-1:0] d, input logic l);
    int guard = 0;
    @(negedge clk);
    pp_valid = 1'b1;
    pp_data  = d;
    pp_last  = l;
    while (!pp_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!pp_ready) check_bit("pp_ready_wait", pp_ready, 1'b1);
    @(posedge clk);
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] exp_d, input logic exp_e);
    for (int i = 0; i < beat_q.size(); i++) send_beat(beat_q[i], i == beat_q.size() - 1);
    @(negedge clk);
    pp_valid = 1'b0;
    pp_last  = 1'b0;
    check_bit({nm, "_resolve_valid"}, res_valid, 1'b0);
    check_bit({nm, "_resolve_ready"}, pp_ready, 1'b0);
    @(negedge clk);
    check_bit({nm, "_valid"}, res_valid, 1'b1);
    check({nm, "_data"}, res_data, exp_d);
    check_bit({nm, "_err"}, res_err, exp_e);
    @(negedge clk);
    check_bit({nm, "_ready_after"}, pp_ready, 1'b1);
    check_bit({nm, "_valid_after"}, res_valid, 1'b0);
  endtask

  initial begin
    int a0;
    int guard;
    int nsel[6] = '{17, 1, 17, 5, 20, 17};

    vecs[0] = '{17, 64'h1, 64'h1, 64'h1, 64'h11, 1'b0};
    vecs[1] = '{17, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 64'h0, 1'b0};
    vecs[2] = '{17, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001,
                64'h8000_0000_0000_0001, 64'h8000_0000_0000_0011, 1'b0};
    vecs[3] = '{3, 64'h1, 64'h2, 64'h3, 64'h6, 1'b1};
    vecs[4] = '{18, 64'h1, 64'h1, 64'h1, 64'h12, 1'b1};
    vecs[5] = '{17, 64'h1, 64'h1, 64'h1, 64'h11, 1'b0};
    vecs[6] = '{1, 64'hDEAD_BEEF_0123_4567, 64'h0, 64'h0, 64'hDEAD_BEEF_0123_4567, 1'b1};

    // Reset state
    @(negedge clk);
    check_bit("rst_pp_ready", pp_ready, 1'b1);
    check_bit("rst_res_valid", res_valid, 1'b0);
    check("rst_res_data", res_data, '0);
    check_bit("rst_res_err", res_err, 1'b0);
    rst = 1'b0;

    // Table-driven operations
    for (int i = 0; i < 7; i++) begin
      beat_q.delete();
      for (int b = 1; b <= vecs[i].nbeats; b++)
        beat_q.push_back(b == 1 ? vecs[i].d0 : (b == 2 ? vecs[i].d1 : vecs[i].drest));
      run_op($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_err);
    end

    // Randomized operations against the modular-sum model
    for (int r = 0; r < 6; r++) begin
      beat_q.delete();
      for (int b = 0; b < nsel[r]; b++) beat_q.push_back({$urandom(), $urandom()});
      run_op($sformatf("rand%0d", r), ref_sum(), beat_q.size() != NPP);
    end

    // Backpressure: result held for 5 cycles while the next beat waits
    res_ready = 1'b0;
    for (int i = 0; i < 17; i++) send_beat(64'h5, i == 16);
    @(negedge clk);
    pp_data = 64'h7;
    pp_last = 1'b0;
    guard = 0;
    while (!res_valid && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check_bit("bp_valid", res_valid, 1'b1);
    a0 = acc_cnt;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_data%0d", k), res_data, 64'h55);
      check_bit($sformatf("bp_ready%0d", k), pp_ready, 1'b0);
      check_bit($sformatf("bp_hold_valid%0d", k), res_valid, 1'b1);
    end
    check("bp_no_accept", 64'(acc_cnt - a0), 64'd0);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_hs_edge_no_accept", 64'(acc_cnt - a0), 64'd0);
    check_bit("bp_ready_after_hs", pp_ready, 1'b1);
    @(posedge clk);
    #1;
    check("bp_accept_next", 64'(acc_cnt - a0), 64'd1);
    beat_q.delete();
    for (int i = 0; i < 16; i++) beat_q.push_back(64'h7);
    run_op("bp_next_op", 64'h77, 1'b0);

    // Back-to-back operations: NPP+2 cycles each
    hs_cyc.delete();
    hs_data.delete();
    for (int i = 0; i < 34; i++) send_beat(64'h3, i == 16 || i == 33);
    @(negedge clk);
    pp_valid = 1'b0;
    pp_last  = 1'b0;
    guard = 0;
    while (hs_cyc.size() < 2 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("b2b_count", 64'(hs_cyc.size()), 64'd2);
    if (hs_cyc.size() >= 2) begin
      check("b2b_period", 64'(hs_cyc[1] - hs_cyc[0]), 64'd19);
      check("b2b_data0", hs_data[0], 64'h33);
      check("b2b_data1", hs_data[1], 64'h33);
    end

    // Asynchronous reset mid-operation
    for (int i = 0; i < 8; i++) send_beat(64'h2, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_bit("mrst_pp_ready", pp_ready, 1'b1);
    check_bit("mrst_res_valid", res_valid, 1'b0);
    check("mrst_res_data", res_data, '0);
    check_bit("mrst_res_err", res_err, 1'b0);
    pp_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    beat_q.delete();
    for (int i = 0; i < 17; i++) beat_q.push_back(64'h2);
    run_op("post_rst", 64'h22, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/booth_pp_accumulator.md
# booth_pp_accumulator

Sequential reducer for the multiplier datapath. It consumes the partial-product words that the radix-4 Booth encoding stage generates, one word per beat on a valid/ready stream, and accumulates them in carry-save form. After the final beat it performs a single carry-propagate add and returns the 64-bit product on an output valid/ready port. It sits between the encoding stage and the FPU mantissa normalisation logic.

## Interface
- `W`, default 64: partial-product and result width in bits.
- `NPP`, default 17: number of partial products expected per operation.
- `CW`, default 5: counter width; must satisfy 2^CW > NPP.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `pp_valid`  in  1  `pp_data` and `pp_last` are valid.
- `pp_ready`  out  1  accumulator accepts a beat this cycle.
- `pp_data`  in  W  partial-product word, pre-aligned and sign-extension-encoded.
- `pp_last`  in  1  marks the final beat of an operation.
- `res_valid`  out  1  `res_data` and `res_err` are valid.
- `res_ready`  in  1  downstream accepts the result.
- `res_data`  out  W  product, equal to the sum of all beats modulo 2^W.
- `res_err`  out  1  the beat count of this operation differed from `NPP`.

## Operation
- Registers:
  - `sum_r[W-1:0]` and `car_r[W-1:0]`: carry-save pair.
  - `cnt_r[CW-1:0]`: beats accepted in the current operation.
  - `err_r`: sticky error flag for the current operation.
  - `res_r[W-1:0]`: result register.
  - `state_r`: one of ACCUM, RESOLVE, DONE.
- A beat is accepted when `pp_valid` and `pp_ready` are both 1.
- ACCUM:
  - `pp_ready` = 1.
  - On an accepted beat: `sum_r` ← `sum_r ^ car_r ^ pp_data`.
  - On the same beat: `car_r` ← ((`sum_r&car_r` | `sum_r&pp_data` | `car_r&pp_data`) << 1), truncated to W bits. The carry out of the MSB is discarded.
  - `cnt_r` increments, saturating at 2^CW−1.
  - If an accepted beat has `pp_last`=0 and `cnt_r`+1 ≥ `NPP`, set `err_r`. The beat is still accumulated.
  - If an accepted beat has `pp_last`=1 and `cnt_r`+1 ≠ `NPP`, set `err_r`. The state moves to RESOLVE.
  - If an accepted beat has `pp_last`=1 and `cnt_r`+1 = `NPP`, the state moves to RESOLVE and `err_r` is unchanged.
- RESOLVE (one cycle):
  - `pp_ready` = 0.
  - `res_r` ← `sum_r` + `car_r`, modulo 2^W.
  - Go to DONE.
- DONE:
  - `pp_ready` = 0. `res_valid` = 1.
  - `res_data` = `res_r`. `res_err` = `err_r`.
  - On `res_valid`&`res_ready`: clear `sum_r`, `car_r`, `cnt_r` and `err_r`, then go to ACCUM.
- Outputs are driven from registers only (`pp_ready`, `res_valid` and `res_err` decode `state_r` and `err_r`). There is no combinational path from inputs to outputs.
- Reset values:
  - `state_r`=ACCUM. `sum_r`, `car_r`, `res_r`, `cnt_r` and `err_r` are all 0.
  - Output values: `pp_ready`=1, `res_valid`=0, `res_data`=0, `res_err`=0.
- Reset mid-operation discards all partial sums and any pending result with no output handshake. The next beat accepted after reset starts a fresh operation.
- A single-beat operation (`pp_last` on beat 1) is legal. It produces the beat value with `res_err`=1, unless `NPP`=1.

## Timing
- Throughput: one beat per cycle in ACCUM. There is no bubble between beats.
- Latency: if the last beat is accepted at edge t, RESOLVE occupies cycle t..t+1 and `res_valid` rises after edge t+1. Result visible two edges after the last beat.
- `res_data` and `res_err` hold stable while `res_valid`=1 and `res_ready`=0, for any number of cycles.
- After the result handshake at edge u, `pp_ready`=1 from edge u. The first beat of the next operation can be accepted at edge u+1.
- Any `pp_valid` asserted while `pp_ready`=0 is ignored. The source must hold the beat.
- Minimum period per operation of `NPP` beats: `NPP`+2 cycles, with `res_ready` tied to 1.

## Test plan
- Basic sum: 17 beats of 0x0000_0000_0000_0001, `pp_last` on beat 17, `res_ready`=1 → `res_data`=0x11, `res_err`=0, `res_valid` two edges after beat 17.
- Wrap-around: beat 1 = 0xFFFF_FFFF_FFFF_FFFF, beat 2 = 0x1, beats 3–17 = 0 → `res_data`=0x0, `res_err`=0.
- Carry-save correctness: 17 beats of 0x8000_0000_0000_0001 → `res_data`=0x8000_0000_0000_0011 (odd count of MSB terms), `res_err`=0. Also 17 random words, checked against a reference modular sum.
- Count errors:
  - 3 beats (1, 2, 3) with `pp_last` on beat 3 → `res_data`=0x6, `res_err`=1.
  - 18 beats of 0x1 with `pp_last` on beat 18 → `res_data`=0x12, `res_err`=1.
  - The following correct 17-beat operation → `res_err`=0.
- Backpressure and handshake: `res_ready`=0 for 5 cycles after `res_valid` rises, with `pp_valid`=1 throughout.
  - `res_data` stays stable and `pp_ready`=0 for all 5 cycles.
  - No beat is accepted until the cycle after `res_ready` goes high.
  - Back-to-back operations complete in 19 cycles each.
- Reset mid-operation: assert `rst` asynchronously after beat 8 (mid-cycle) → all outputs at reset values immediately. A subsequent 17-beat operation of 0x2 → `res_data`=0x22, `res_err`=0.
